mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, 32, width of all address buses.
REQ-002 Parameter DATA_W, 32, width of all data buses (instruction word = data word).
REQ-003 clk  in  1  single system clock, all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 if_req  in  1  instruction-fetch read request, held until if_ack.
REQ-006 if_addr  in  ADDR_W  fetch byte address, word-aligned.
REQ-007 if_ack  out  1  one-cycle pulse, if_inst valid.
REQ-008 if_inst  out  DATA_W  fetched instruction word.
REQ-009 flush  in  1  pipeline flush; cancels delivery of an in-flight fetch.
REQ-010 mem_req  in  1  load/store request, held until mem_ack.
REQ-011 mem_we  in  1  1 = store, 0 = load.
REQ-012 mem_addr  in  ADDR_W  load/store byte address.
REQ-013 mem_sel  in  4  byte-lane enables.
REQ-014 mem_wdata  in  DATA_W  store data.
REQ-015 mem_ack  out  1  one-cycle pulse, access complete, mem_rdata valid on loads.
REQ-016 mem_rdata  out  DATA_W  load data.
REQ-017 ram_ce  out  1  shared memory port chip enable.
REQ-018 ram_we / ram_addr / ram_sel / ram_wdata  out  1/ADDR_W/4/DATA_W  shared port command.
REQ-019 ram_ack  in  1  memory completion, ram_rdata valid same cycle.
REQ-020 ram_rdata  in  DATA_W  memory read data.
REQ-021 stall_req  out  1  pipeline stall request to the pipeline controller.

Function
REQ-022 FSM states IDLE, BUSY_IF, BUSY_MEM; the FSM holds at most one memory transaction at a time.
REQ-023 IDLE: only mem_req -> BUSY_MEM; only if_req -> BUSY_IF; both -> the winner per REQ-032; neither -> stay IDLE.
REQ-024 On grant, ram_* are registered from the winner's inputs, and ram_ce = 1 from the next cycle.
REQ-025 For an IF grant: ram_we = 0, ram_sel = 4'b1111.
REQ-026 BUSY_x: ram_* are held stable until ram_ack = 1 is sampled.
REQ-027 When ram_ack = 1 is sampled:
- ram_ce = 0 and the FSM returns to IDLE on that edge.
- x_ack = 1 for exactly the following cycle.
- x_inst / x_rdata = ram_rdata as captured at that edge.
REQ-028 Minimum request-to-ack latency is 2 cycles: grant edge, then ram_ack in the first ram_ce cycle.
REQ-029 rdata/inst outputs hold their last captured value between acks; mem_rdata is undefined-but-stable after a store.
REQ-030 A request still high in IDLE, including the ack cycle, is a new request; back-to-back grants are legal.
REQ-031 Flush:
- flush = 1 in BUSY_IF, or in the cycle a BUSY_IF transaction is granted, sets a cancel flag.
- The memory transaction still completes.
- if_ack is suppressed for it.
- The cancel flag clears on return to IDLE.
- flush has no effect on MEM transactions.
REQ-032 Contention without ARB_RR_EN: MEM always wins.
REQ-033 stall_req = (if_req & ~if_ack) | (mem_req & ~mem_ack), combinational.
REQ-034 Requests dropped mid-transaction do not abort the transaction; its ack still pulses.

Reset
REQ-035 While rst = 1, asynchronously:
- state = IDLE; ram_ce = ram_we = 0; ram_addr = ram_wdata = 0; ram_sel = 0.
- if_ack = mem_ack = 0; if_inst = mem_rdata = 0.
- cancel flag = 0; last-grant register = IF.
REQ-036 Reset during BUSY_x abandons the transaction; no ack is issued after reset release.

Configuration
REQ-037 Macro ARB_RR_EN defined:
- On contention the requester not granted last wins.
- The last-grant register updates on every grant.
- After reset the first contention goes to MEM.
REQ-038 Macro ARB_RR_EN undefined: fixed priority per REQ-032; the last-grant register is absent.

Verification
REQ-039 if_req = 1, if_addr = 0x4, ram_ack in first ram_ce cycle, ram_rdata = 0x00226293 -> ram_addr = 0x4, ram_sel = 4'hF; if_ack pulses 2 cycles after request with if_inst = 0x00226293.
REQ-040 if_req and mem_req (store 0xDEADBEEF to 0x100, sel 4'hF) rise together:
- MEM granted first.
- Fixed priority: repeated contention stays MEM.
- ARB_RR_EN: next contention grants IF.
REQ-041 ram_ack delayed 3 cycles -> ram_* stable throughout, stall_req = 1 until the ack cycle, exactly one mem_ack.
REQ-042 flush = 1 during BUSY_IF -> the transaction completes on the ram port, no if_ack, FSM returns to IDLE.
REQ-043 rst asserted in BUSY_MEM -> ram_ce = 0 immediately; no mem_ack after release.
REQ-044 if_req held high across if_ack, addresses 0x0, 0x4, 0x8 -> three back-to-back fetches, each ack 1 cycle after its ram_ack.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shared-memory arbiter between instruction fetch and load/store ports; one transaction in flight.
// Optional round-robin contention resolution is enabled by defining ARB_RR_EN.
module mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic [DATA_W-1:0] if_inst,
   input  logic              flush,
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [3:0]        mem_sel,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic              mem_ack,
   output logic [DATA_W-1:0] mem_rdata,
   output logic              ram_ce,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [3:0]        ram_sel,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic              ram_ack,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              stall_req
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BUSY_IF,
      ST_BUSY_MEM
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_cancel;
   logic              w_cancel_nxt;
   logic              w_grant_if;
   logic              w_grant_mem;
   logic              w_mem_prio;
   logic              w_done;
   logic              w_if_deliver;
   logic              w_mem_deliver;

   logic              r_if_ack;
   logic              r_mem_ack;
   logic [DATA_W-1:0] r_if_inst;
   logic [DATA_W-1:0] r_mem_rdata;
   logic              r_ram_ce;
   logic              r_ram_we;
   logic [ADDR_W-1:0] r_ram_addr;
   logic [3:0]        r_ram_sel;
   logic [DATA_W-1:0] r_ram_wdata;

`ifdef ARB_RR_EN
   logic r_last_mem;

   // MEM wins contention whenever IF held the previous grant (IF after reset).
   assign w_mem_prio = ~r_last_mem;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_last_mem <= 1'b0;
      else if (w_grant_if || w_grant_mem)
         r_last_mem <= w_grant_mem;
   end
`else
   assign w_mem_prio = 1'b1;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_cancel <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cancel <= w_cancel_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_cancel_nxt  = r_cancel;
      w_grant_if    = 1'b0;
      w_grant_mem   = 1'b0;
      w_done        = 1'b0;
      w_if_deliver  = 1'b0;
      w_mem_deliver = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_cancel_nxt = 1'b0;
            w_grant_mem  = mem_req & (~if_req | w_mem_prio);
            w_grant_if   = if_req & ~w_grant_mem;
            if (w_grant_mem) begin
               w_state_nxt = ST_BUSY_MEM;
            end else if (w_grant_if) begin
               w_state_nxt  = ST_BUSY_IF;
               w_cancel_nxt = flush;
            end
         end
         ST_BUSY_IF: begin
            if (ram_ack) begin
               w_done       = 1'b1;
               // A flush coinciding with completion still suppresses delivery.
               w_if_deliver = ~r_cancel & ~flush;
               w_cancel_nxt = 1'b0;
               w_state_nxt  = ST_IDLE;
            end else begin
               w_cancel_nxt = r_cancel | flush;
            end
         end
         ST_BUSY_MEM: begin
            if (ram_ack) begin
               w_done        = 1'b1;
               w_mem_deliver = 1'b1;
               w_state_nxt   = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_if_ack    <= 1'b0;
         r_mem_ack   <= 1'b0;
         r_if_inst   <= '0;
         r_mem_rdata <= '0;
         r_ram_ce    <= 1'b0;
         r_ram_we    <= 1'b0;
         r_ram_addr  <= '0;
         r_ram_sel   <= '0;
         r_ram_wdata <= '0;
      end else begin
         r_if_ack  <= w_if_deliver;
         r_mem_ack <= w_mem_deliver;
         if (w_if_deliver)
            r_if_inst <= ram_rdata;
         if (w_mem_deliver)
            r_mem_rdata <= ram_rdata;
         if (w_grant_mem) begin
            r_ram_ce    <= 1'b1;
            r_ram_we    <= mem_we;
            r_ram_addr  <= mem_addr;
            r_ram_sel   <= mem_sel;
            r_ram_wdata <= mem_wdata;
         end else if (w_grant_if) begin
            r_ram_ce   <= 1'b1;
            r_ram_we   <= 1'b0;
            r_ram_addr <= if_addr;
            r_ram_sel  <= '1;
         end else if (w_done) begin
            r_ram_ce <= 1'b0;
         end
      end
   end

   assign if_ack    = r_if_ack;
   assign if_inst   = r_if_inst;
   assign mem_ack   = r_mem_ack;
   assign mem_rdata = r_mem_rdata;
   assign ram_ce    = r_ram_ce;
   assign ram_we    = r_ram_we;
   assign ram_addr  = r_ram_addr;
   assign ram_sel   = r_ram_sel;
   assign ram_wdata = r_ram_wdata;
   assign stall_req = (if_req & ~r_if_ack) | (mem_req & ~r_mem_ack);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then randomized
// traffic checked every cycle against a transaction-level model.
module tb_mem_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          if_req = 1'b0;
   logic [AW-1:0] if_addr = '0;
   logic          if_ack;
   logic [DW-1:0] if_inst;
   logic          flush = 1'b0;
   logic          mem_req = 1'b0;
   logic          mem_we = 1'b0;
   logic [AW-1:0] mem_addr = '0;
   logic [3:0]    mem_sel = '0;
   logic [DW-1:0] mem_wdata = '0;
   logic          mem_ack;
   logic [DW-1:0] mem_rdata;
   logic          ram_ce;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [3:0]    ram_sel;
   logic [DW-1:0] ram_wdata;
   logic          ram_ack = 1'b0;
   logic [DW-1:0] ram_rdata = '0;
   logic          stall_req;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_inst(if_inst),
      .flush(flush),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_sel(mem_sel),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_sel(ram_sel),
      .ram_wdata(ram_wdata), .ram_ack(ram_ack), .ram_rdata(ram_rdata),
      .stall_req(stall_req)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   bit done  = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: one outstanding transaction record plus delivered results.
   logic          m_busy = 1'b0;
   logic          m_is_if = 1'b0;
   logic          m_cancel = 1'b0;
   logic          m_we = 1'b0;
   logic [AW-1:0] m_addr = '0;
   logic [3:0]    m_sel = '0;
   logic [DW-1:0] m_wdata = '0;
   logic          m_if_ack = 1'b0;
   logic          m_mem_ack = 1'b0;
   logic [DW-1:0] m_inst = '0;
   logic [DW-1:0] m_rdata = '0;
   logic          m_rvalid = 1'b1;
   logic          m_last_mem = 1'b0;
   logic          m_mem_wins;
   int            m_grants = 0;

   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         m_busy = 1'b0; m_cancel = 1'b0; m_if_ack = 1'b0; m_mem_ack = 1'b0;
         m_inst = '0; m_rdata = '0; m_rvalid = 1'b1; m_last_mem = 1'b0;
      end else begin
         m_if_ack  = 1'b0;
         m_mem_ack = 1'b0;
         if (m_busy) begin
            if (ram_ack) begin
               if (m_is_if) begin
                  if (!m_cancel && !flush) begin
                     m_if_ack = 1'b1;
                     m_inst   = ram_rdata;
                  end
               end else begin
                  m_mem_ack = 1'b1;
                  m_rdata   = ram_rdata;
                  m_rvalid  = !m_we;
               end
               m_busy   = 1'b0;
               m_cancel = 1'b0;
            end else if (m_is_if && flush) begin
               m_cancel = 1'b1;
            end
         end else if (if_req || mem_req) begin
`ifdef ARB_RR_EN
            m_mem_wins = mem_req && (!if_req || !m_last_mem);
`else
            m_mem_wins = mem_req;
`endif
            if (m_mem_wins) begin
               m_is_if = 1'b0; m_we = mem_we; m_addr = mem_addr;
               m_sel = mem_sel; m_wdata = mem_wdata; m_cancel = 1'b0;
            end else begin
               m_is_if = 1'b1; m_we = 1'b0; m_addr = if_addr;
               m_sel = 4'hF; m_cancel = flush;
            end
            m_last_mem = m_mem_wins;
            m_busy     = 1'b1;
            m_grants++;
         end
      end
   end

   // Compare process: every cycle, away from the active edge.
   initial forever begin
      @(negedge clk);
      if (!done) begin
         chk("ram_ce", ram_ce, m_busy);
         chk("if_ack", if_ack, m_if_ack);
         chk("mem_ack", mem_ack, m_mem_ack);
         chk("if_inst", if_inst, m_inst);
         chk("stall_req", stall_req, (if_req & ~m_if_ack) | (mem_req & ~m_mem_ack));
         if (m_rvalid)
            chk("mem_rdata", mem_rdata, m_rdata);
         if (m_busy) begin
            chk("ram_we", ram_we, m_we);
            chk("ram_addr", ram_addr, m_addr);
            chk("ram_sel", ram_sel, m_sel);
            if (!m_is_if)
               chk("ram_wdata", ram_wdata, m_wdata);
         end
      end
   end

   logic [DW-1:0] exp_inst;
   int            seen_grants = 0;
   int            wait_left = 0;

   initial begin
      repeat (2) @(negedge clk);
      chk("rst_ram_ce", ram_ce, 1'b0);
      chk("rst_ram_we", ram_we, 1'b0);
      chk("rst_ram_addr", ram_addr, 32'h0);
      chk("rst_ram_sel", ram_sel, 4'h0);
      chk("rst_ram_wdata", ram_wdata, 32'h0);
      chk("rst_if_ack", if_ack, 1'b0);
      chk("rst_mem_ack", mem_ack, 1'b0);
      chk("rst_if_inst", if_inst, 32'h0);
      chk("rst_mem_rdata", mem_rdata, 32'h0);
      #1 rst = 1'b0;

      // Single fetch, minimum latency
      @(negedge clk); #1 if_req = 1'b1; if_addr = 32'h4;
      @(negedge clk);
      chk("f1_ce", ram_ce, 1'b1); chk("f1_addr", ram_addr, 32'h4);
      chk("f1_sel", ram_sel, 4'hF); chk("f1_we", ram_we, 1'b0);
      chk("f1_stall", stall_req, 1'b1);
      #1 ram_ack = 1'b1; ram_rdata = 32'h0022_6293;
      @(negedge clk);
      chk("f1_ack", if_ack, 1'b1); chk("f1_inst", if_inst, 32'h0022_6293);
      chk("f1_ce_off", ram_ce, 1'b0); chk("f1_stall_off", stall_req, 1'b0);
      #1 ram_ack = 1'b0; if_req = 1'b0; ram_rdata = '0;
      @(negedge clk);
      chk("f1_ack_pulse", if_ack, 1'b0); chk("f1_inst_hold", if_inst, 32'h0022_6293);

      // Contention: store wins first, then priority policy decides the second
      #1 if_req = 1'b1; if_addr = 32'h10;
      mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h100; mem_sel = 4'hF; mem_wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("c1_we", ram_we, 1'b1); chk("c1_addr", ram_addr, 32'h100);
      chk("c1_wdata", ram_wdata, 32'hDEAD_BEEF); chk("c1_sel", ram_sel, 4'hF);
      #1 ram_ack = 1'b1;
      @(negedge clk);
      chk("c1_mem_ack", mem_ack, 1'b1); chk("c1_if_ack", if_ack, 1'b0);
      #1 ram_ack = 1'b0;
      @(negedge clk);
      chk("c2_ce", ram_ce, 1'b1);
`ifdef ARB_RR_EN
      chk("c2_we", ram_we, 1'b0); chk("c2_addr", ram_addr, 32'h10);
      exp_inst = 32'h0BAD_F00D;
`else
      chk("c2_we", ram_we, 1'b1); chk("c2_addr", ram_addr, 32'h100);
      exp_inst = 32'h0022_6293;
`endif
      #1 ram_ack = 1'b1; ram_rdata = 32'h0BAD_F00D;
      @(negedge clk);
`ifdef ARB_RR_EN
      chk("c2_if_ack", if_ack, 1'b1); chk("c2_inst", if_inst, 32'h0BAD_F00D);
`else
      chk("c2_mem_ack", mem_ack, 1'b1); chk("c2_if_ack", if_ack, 1'b0);
`endif
      #1 ram_ack = 1'b0; if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
      @(negedge clk);
      chk("c2_idle", ram_ce, 1'b0);

      // Load with ram_ack delayed three cycles
      #1 mem_req = 1'b1; mem_addr = 32'h200; mem_sel = 4'h3;
      @(negedge clk);
      chk("d_ce", ram_ce, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("d_ce_hold", ram_ce, 1'b1); chk("d_addr_hold", ram_addr, 32'h200);
         chk("d_sel_hold", ram_sel, 4'h3); chk("d_stall", stall_req, 1'b1);
         chk("d_no_ack", mem_ack, 1'b0);
      end
      #1 ram_ack = 1'b1; ram_rdata = 32'h1234_5678;
      @(negedge clk);
      chk("d_ack", mem_ack, 1'b1); chk("d_rdata", mem_rdata, 32'h1234_5678);
      chk("d_stall_off", stall_req, 1'b0);
      #1 ram_ack = 1'b0; mem_req = 1'b0;
      @(negedge clk);
      chk("d_ack_once", mem_ack, 1'b0); chk("d_ce_off", ram_ce, 1'b0);

      // Flush during a fetch
      #1 if_req = 1'b1; if_addr = 32'h8;
      @(negedge clk);
      chk("fl_ce", ram_ce, 1'b1);
      #1 flush = 1'b1;
      @(negedge clk);
      chk("fl_ce_hold", ram_ce, 1'b1);
      #1 flush = 1'b0; if_req = 1'b0; ram_ack = 1'b1; ram_rdata = 32'hFFFF_0000;
      @(negedge clk);
      chk("fl_no_ack", if_ack, 1'b0); chk("fl_idle", ram_ce, 1'b0);
      chk("fl_inst_hold", if_inst, exp_inst);
      #1 ram_ack = 1'b0;
      @(negedge clk);
      chk("fl_no_ack2", if_ack, 1'b0);

      // Reset in the middle of a load
      #1 mem_req = 1'b1; mem_addr = 32'h300;
      @(negedge clk);
      chk("r_ce", ram_ce, 1'b1);
      #1 rst = 1'b1; ram_ack = 1'b1;
      #1 chk("r_ce_async", ram_ce, 1'b0);
      @(negedge clk); #1 rst = 1'b0; mem_req = 1'b0; ram_ack = 1'b0;
      repeat (2) begin
         @(negedge clk);
         chk("r_no_ack", mem_ack, 1'b0); chk("r_ce_off", ram_ce, 1'b0);
      end

      // Back-to-back fetches with if_req held through each ack
      #1 if_req = 1'b1; if_addr = 32'h0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("bb_ce", ram_ce, 1'b1); chk("bb_addr", ram_addr, 32'(4 * k));
         #1 ram_ack = 1'b1; ram_rdata = 32'(32'hA0 + k);
         @(negedge clk);
         chk("bb_ack", if_ack, 1'b1); chk("bb_inst", if_inst, 32'(32'hA0 + k));
         #1 ram_ack = 1'b0;
         if (k < 2) if_addr = 32'(4 * (k + 1));
         else if_req = 1'b0;
      end
      @(negedge clk);
      chk("bb_end_ack", if_ack, 1'b0); chk("bb_end_ce", ram_ce, 1'b0);

      // Randomized traffic
      for (int c = 0; c < 4000; c++) begin
         #1;
         rst = ($urandom_range(0, 399) == 0);
         flush = ($urandom_range(0, 7) == 0);
         ram_rdata = $urandom;
         if (m_busy) begin
            if (m_grants != seen_grants) begin
               seen_grants = m_grants;
               wait_left = $urandom_range(0, 3);
            end
            if (wait_left == 0) ram_ack = 1'b1;
            else begin ram_ack = 1'b0; wait_left--; end
         end else begin
            ram_ack = ($urandom_range(0, 3) == 0);
         end
         if (if_req && !m_if_ack) begin
            if (flush) if_req = $urandom_range(0, 1) == 1;
         end else begin
            if_req  = $urandom_range(0, 1) == 1;
            if_addr = $urandom & 32'hFFFF_FFFC;
         end
         if (!(mem_req && !m_mem_ack)) begin
            mem_req   = $urandom_range(0, 1) == 1;
            mem_we    = $urandom_range(0, 1) == 1;
            mem_addr  = $urandom & 32'hFFFF_FFFC;
            mem_sel   = 4'($urandom);
            mem_wdata = $urandom;
         end
         @(negedge clk);
      end
      @(negedge clk);
      done = 1'b1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
